// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_BYTES     = 512;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } imem_ld_state_t;

    // Big-endian byte lane: index 0 is the most significant byte.
    function automatic logic [7:0] be_byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        case (idx)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            2'd3:    lane = word[7:0];
            default: lane = 8'd0;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Picks one big-endian byte of a 32-bit word and flags the final byte.
module word_byte_serializer
    import imem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_idx,
    output logic [7:0]  byte_lane,
    output logic        last_byte
);

    // Byte lane selection and last-byte detection.
    always_comb begin
        byte_lane = be_byte_lane(word, byte_idx);
        last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit words into the byte-wide instruction memory, MSB first.
// All outputs are registered; they are loaded from the next-state values so
// that a write is visible in the cycle directly after the accepting edge.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  word_count
);

    localparam logic [63:0] MEM_END  = 64'(MEM_BYTES);
    localparam logic [63:0] BASE_PTR = 64'(BASE_ADDR);
    localparam logic [63:0] WORD_INC = 64'(BYTES_PER_WORD);

    imem_ld_state_t state_r, state_next;
    logic [63:0]    ptr_r, ptr_next;
    logic [1:0]     idx_r, idx_next;
    logic [31:0]    word_r, word_next;
    logic           last_r, last_next;
    logic [7:0]     count_r, count_next;
    logic           session_start_s;
    logic [7:0]     lane_s;
    logic           last_byte_s;

    logic           in_ready_r;
    logic           mem_we_r;
    logic [63:0]    mem_addr_r;
    logic [7:0]     mem_wdata_r;
    logic           busy_r;
    logic           done_r;
    logic           error_r;

    // Byte about to be presented, derived from the next-cycle word and index.
    word_byte_serializer u_ser (
        .word      (word_next),
        .byte_idx  (idx_next),
        .byte_lane (lane_s),
        .last_byte (last_byte_s)
    );

    // Next-state, pointer, byte index and latched word.
    always_comb begin
        state_next      = state_r;
        ptr_next        = ptr_r;
        idx_next        = idx_r;
        word_next       = word_r;
        last_next       = last_r;
        session_start_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next      = ST_ACCEPT;
                    ptr_next        = BASE_PTR;
                    idx_next        = 2'd0;
                    session_start_s = 1'b1;
                end else begin
                    state_next = state_r;
                end
            end
            ST_ACCEPT: begin
                // A full pointer ends the session before any word is taken.
                if (ptr_r == MEM_END) begin
                    state_next = ST_ERR;
                end else if (in_valid && in_ready_r) begin
                    word_next  = in_word;
                    last_next  = in_last;
                    idx_next   = 2'd0;
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_ACCEPT;
                end
            end
            ST_WRITE: begin
                if (idx_r == 2'(BYTES_PER_WORD - 1)) begin
                    ptr_next   = ptr_r + WORD_INC;
                    idx_next   = 2'd0;
                    state_next = last_r ? ST_DONE : ST_ACCEPT;
                end else begin
                    idx_next   = idx_r + 2'd1;
                    state_next = ST_WRITE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Word counter: cleared on session start, bumped as the final byte goes out.
    always_comb begin
        count_next = count_r;
        if (session_start_s) begin
            count_next = 8'd0;
        end else if ((state_r == ST_WRITE) && (state_next == ST_WRITE) && last_byte_s) begin
            count_next = count_r + 8'd1;
        end else begin
            count_next = count_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= BASE_PTR;
            idx_r       <= 2'd0;
            word_r      <= 32'd0;
            last_r      <= 1'b0;
            count_r     <= 8'd0;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 64'd0;
            mem_wdata_r <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_next;
            ptr_r       <= ptr_next;
            idx_r       <= idx_next;
            word_r      <= word_next;
            last_r      <= last_next;
            count_r     <= count_next;
            in_ready_r  <= (state_next == ST_ACCEPT) && (ptr_next != MEM_END);
            mem_we_r    <= (state_next == ST_WRITE);
            mem_addr_r  <= (state_next == ST_WRITE) ? (ptr_next + {62'd0, idx_next}) : 64'd0;
            mem_wdata_r <= (state_next == ST_WRITE) ? lane_s : 8'd0;
            busy_r      <= (state_next == ST_ACCEPT) || (state_next == ST_WRITE);
            done_r      <= (state_next == ST_DONE);
            error_r     <= (state_next == ST_ERR);
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = count_r;

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory. Accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-wide instruction memory in big-endian byte order: MSB at the lowest address, so a later fetch at `address` returns the same word. Sits between the boot/debug host path and the instruction memory write port, and holds the core off via `busy` while loading.

## Interface

**Parameters**
- `MEM_BYTES`, 512: instruction memory size in bytes; must be a multiple of 4.
- `BASE_ADDR`, 0: byte address of the first word written; must be a multiple of 4 and less than `MEM_BYTES`.

**Ports**
- `clk` input, 1: single clock; all logic is on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `start` input, 1: one-cycle pulse that begins a load session.
- `in_valid` input, 1: the input word is valid.
- `in_ready` output, 1: the loader accepts a word this cycle.
- `in_word` input, 32: the instruction word.
- `in_last` input, 1: marks the final word of the session; sampled with the word.
- `mem_we` output, 1: byte write strobe to the instruction memory.
- `mem_addr` output, 64: byte address for the write.
- `mem_wdata` output, 8: byte to write.
- `busy` output, 1: a session is in progress; the core must be held.
- `done` output, 1: the session completed normally; sticky.
- `error` output, 1: the session overflowed memory; sticky.
- `word_count` output, 8: number of words fully written this session.

## Operation

States: IDLE, ACCEPT, WRITE, DONE, ERR.

- **Reset:** state goes to IDLE.
  - `in_ready`, `mem_we`, `busy`, `done`, `error` are 0.
  - `mem_addr`, `mem_wdata`, `word_count` are 0.
  - Write pointer is `BASE_ADDR`.
- **IDLE, DONE, ERR with `start`=1:** go to ACCEPT.
  - Pointer is set to `BASE_ADDR`; `word_count` is set to 0.
  - `done` and `error` are cleared; `busy` is set to 1.
- **`start` while in ACCEPT or WRITE:** ignored.
- **ACCEPT:** `in_ready`=1.
  - If the pointer equals `MEM_BYTES`, go to ERR instead; `in_ready` is 0 in that cycle and no word is accepted.
  - On `in_valid && in_ready`: latch `in_word` and `in_last`, go to WRITE with byte index 0.
- **WRITE:** four consecutive cycles with `mem_we`=1.
  - Byte i (i = 0..3) has `mem_addr` = pointer + i and `mem_wdata` = `in_word[31-8i -: 8]`.
  - After byte 3: pointer += 4 and `word_count` += 1.
  - Then go to DONE if the latched last flag is set, else back to ACCEPT.
- **DONE:** `busy`=0, `done`=1.
- **ERR:** `busy`=0, `error`=1; the stream is not drained.
- **Address arithmetic:** 64-bit unsigned. The pointer never exceeds `MEM_BYTES`, because bases are aligned and the size is a multiple of 4.
- **Reset mid-WRITE:** the partial word is abandoned and `mem_we` is 0 from the next cycle. Bytes already written stay in memory.

## Timing

- Outputs are registered. `in_ready` is decoded from the registered state, with no combinational path from `in_valid`.
- A word accepted at edge T drives `mem_we`=1 in cycles T+1 through T+4.
- Throughput: 1 word per 5 cycles. Back-to-back `in_valid` is legal.
- `in_ready` is 0 during WRITE. The sender must hold `in_word` and `in_last` stable while `in_valid`=1 and `in_ready`=0.
- `word_count` increments in the same cycle the last byte's write is presented.
- For a `last` word:
  - `done` rises 1 cycle after byte 3 (at T+5).
  - `busy` falls in that same cycle.
- Overflow: `error` rises 1 cycle after entering ACCEPT with a full pointer.

## Structure

- **Shared package `imem_pkg`:**
  - State enum `imem_ld_state_t`.
  - `BYTES_PER_WORD` = 4.
  - Default `IMEM_BYTES` = 512, also used by the instruction memory.
- **Sub-module `word_byte_serializer`:**
  - Takes a latched 32-bit word and a 2-bit byte index.
  - Produces the big-endian byte lane and the `last_byte` flag.
  - Used by the WRITE state.

## Test plan

- **Single word:** reset, `start`, then word 0x00500093 with `last`.
  - Expect `mem_we` for 4 cycles: addr 0..3, data 0x00, 0x50, 0x00, 0x93.
  - Then `done`=1, `word_count`=1, `busy`=0.
- **Readback:** three words 0x11223344, 0xAABBCCDD, 0x0000006F (`last`) with `in_valid` held high.
  - Expect 12 writes at addr 0..11 and `in_ready` pulses spaced 5 cycles apart.
  - Instruction memory fetch at 4 returns 0xAABBCCDD.
- **Overflow:** `MEM_BYTES`=8, send 3 words, none marked `last`.
  - Expect 8 writes, then `error`=1, `word_count`=2.
  - Third word is never accepted: `in_ready` stays 0.
- **Backpressure and restart:** `in_valid` low for 10 cycles mid-session.
  - Expect no writes and `busy` held at 1.
  - After `done`, a second `start` rewrites from `BASE_ADDR` and clears `done`.
- **Reset mid-WRITE:** assert `reset` after byte 1 of 0xDEADBEEF.
  - Expect `mem_we`=0 next cycle and every output at its reset value.
  - Bytes 0xDE and 0xAD remain in memory.
- **`start` while busy:** pulse `start` during WRITE.
  - Expect no effect: pointer, `word_count` and state continue unchanged.
